multi_edge_counter: RTL

MULTI_EDGE_COUNTER -- requirements
Module: multi_edge_counter

---
 rtl/multi_edge_counter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multi_edge_counter.sv
// Multi-channel gated event counter. Each channel reports START, CYCLIC and STOP
// packets through one round-robin arbitrated valid/ready output register.
module multi_edge_counter #(
    parameter int CH       = 4,
    parameter int WIDTH    = 16,
    parameter int PERIOD   = 10_000_000,
    parameter int SATURATE = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [CH-1:0]                           enable,
    input  logic [CH-1:0]                           inc,
    output logic [CH*WIDTH-1:0]                     count,
    output logic [CH-1:0]                           ovf,
    output logic                                    pkt_valid,
    input  logic                                    pkt_ready,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  pkt_ch,
    output logic [1:0]                              pkt_kind,
    output logic [WIDTH-1:0]                        pkt_count,
    output logic                                    pkt_ovf,
    output logic                                    pkt_drop
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int TW  = $clog2(PERIOD);

    localparam logic [1:0] KIND_START  = 2'd0;
    localparam logic [1:0] KIND_CYCLIC = 2'd1;
    localparam logic [1:0] KIND_STOP   = 2'd2;

    logic [CH-1:0]    en_q, en_d, rise, fall;
    logic [WIDTH-1:0] cnt_q [CH];
    logic [WIDTH-1:0] cnt_d [CH];
    logic [CH-1:0]    ovf_q, ovf_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             tick;
    logic [CH-1:0]    slot_v_q, slot_v_d;
    logic [1:0]       slot_k_q [CH];
    logic [1:0]       slot_k_d [CH];
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic             drop_set;

    logic             found, load;
    logic [CHW-1:0]   gnt_idx;
    logic [CH-1:0]    gnt_oh;
    logic [1:0]       sel_kind;
    logic [WIDTH-1:0] sel_cnt;
    logic             sel_ovf;

    logic             pkt_valid_q, pkt_valid_d;
    logic [CHW-1:0]   pkt_ch_q, pkt_ch_d;
    logic [1:0]       pkt_kind_q, pkt_kind_d;
    logic [WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic             pkt_ovf_q, pkt_ovf_d;
    logic             pkt_drop_q, pkt_drop_d;

    assign en_d = enable;
    assign rise = enable & ~en_q;
    assign fall = ~enable & en_q;
    assign tick = (tmr_q == TW'(PERIOD - 1));
    assign tmr_d = tick ? '0 : tmr_q + TW'(1);

    // Round-robin: first pass covers channels at or above the pointer, second wraps below it.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        gnt_oh   = '0;
        sel_kind = KIND_START;
        sel_cnt  = '0;
        sel_ovf  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (!found && slot_v_q[i] && (CHW'(i) >= ptr_q)) begin
                found = 1'b1; gnt_idx = CHW'(i); gnt_oh[i] = 1'b1;
                sel_kind = slot_k_q[i]; sel_cnt = cnt_q[i]; sel_ovf = ovf_q[i];
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (!found && slot_v_q[i] && (CHW'(i) < ptr_q)) begin
                found = 1'b1; gnt_idx = CHW'(i); gnt_oh[i] = 1'b1;
                sel_kind = slot_k_q[i]; sel_cnt = cnt_q[i]; sel_ovf = ovf_q[i];
            end
        end
        load = (!pkt_valid_q || pkt_ready) && found;
        if (!load) gnt_oh = '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load) ptr_d = (gnt_idx == CHW'(CH - 1)) ? '0 : gnt_idx + CHW'(1);
    end

    always_comb begin
        logic       occ_v, post_v;
        logic [1:0] post_k;
        drop_set = 1'b0;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (rise[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (enable[i] && inc[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end

            post_v = rise[i] || fall[i] || (tick && en_q[i]);
            post_k = rise[i] ? KIND_START : (fall[i] ? KIND_STOP : KIND_CYCLIC);
            // A slot granted this cycle is already free for the new event.
            occ_v       = slot_v_q[i] && !gnt_oh[i];
            slot_v_d[i] = occ_v;
            slot_k_d[i] = slot_k_q[i];
            if (post_v) begin
                if (post_k != KIND_CYCLIC) begin
                    if (occ_v && (slot_k_q[i] != KIND_CYCLIC)) drop_set = 1'b1;
                    slot_v_d[i] = 1'b1;
                    slot_k_d[i] = post_k;
                end else if (!occ_v) begin
                    slot_v_d[i] = 1'b1;
                    slot_k_d[i] = KIND_CYCLIC;
                end
            end
        end
    end

    always_comb begin
        pkt_valid_d = pkt_valid_q;
        pkt_ch_d    = pkt_ch_q;
        pkt_kind_d  = pkt_kind_q;
        pkt_count_d = pkt_count_q;
        pkt_ovf_d   = pkt_ovf_q;
        pkt_drop_d  = pkt_drop_q | drop_set;
        if (load) begin
            pkt_valid_d = 1'b1;
            pkt_ch_d    = gnt_idx;
            pkt_kind_d  = sel_kind;
            pkt_count_d = sel_cnt;
            pkt_ovf_d   = sel_ovf;
        end else if (pkt_ready) begin
            pkt_valid_d = 1'b0;
        end
    end

    // NOTE: the per-channel arrays are small register files, so they take the reset like any other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= '0;
            ovf_q       <= '0;
            tmr_q       <= '0;
            slot_v_q    <= '0;
            ptr_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_ch_q    <= '0;
            pkt_kind_q  <= KIND_START;
            pkt_count_q <= '0;
            pkt_ovf_q   <= 1'b0;
            pkt_drop_q  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i]    <= '0;
                slot_k_q[i] <= KIND_START;
            end
        end else begin
            en_q        <= en_d;
            ovf_q       <= ovf_d;
            tmr_q       <= tmr_d;
            slot_v_q    <= slot_v_d;
            ptr_q       <= ptr_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_ch_q    <= pkt_ch_d;
            pkt_kind_q  <= pkt_kind_d;
            pkt_count_q <= pkt_count_d;
            pkt_ovf_q   <= pkt_ovf_d;
            pkt_drop_q  <= pkt_drop_d;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                slot_k_q[i] <= slot_k_d[i];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < CH; i++) count[i*WIDTH +: WIDTH] = cnt_q[i];
    end

    assign ovf       = ovf_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_ch    = pkt_ch_q;
    assign pkt_kind  = pkt_kind_q;
    assign pkt_count = pkt_count_q;
    assign pkt_ovf   = pkt_ovf_q;
    assign pkt_drop  = pkt_drop_q;

endmodule
